// File: rtl/unpooler_pkg.sv
// rtl/unpooler_pkg.sv - shared types and helpers for the 2x2 unpooler
package unpooler_pkg;

    localparam int DATA_W_DEF = 32;

    // Same encoding the pooler uses, so both blocks decode identically.
    typedef enum logic [1:0] {
        FILL_A = 2'd0,
        FILL_B = 2'd1,
        REPLAY = 2'd2
    } state_t;

    // Counter width for a count range of n values, never below one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/unpooler_if.sv
// rtl/unpooler_if.sv - pixel stream handshake between upstream, unpooler and downstream
//
// ce, data_in      : upstream -> unpooler (data held while pause_inputs=1)
// data_out         : upsampled sample
// valid_op, end_op : new pixel this cycle / last pixel of frame
// pause_inputs     : unpooler -> upstream throttle
interface unpooler_if #(
    parameter int DATA_W = 32
);
    logic              ce;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_op;
    logic              end_op;
    logic              pause_inputs;

    modport slave (
        input  ce,
        input  data_in,
        output data_out,
        output valid_op,
        output end_op,
        output pause_inputs
    );

    modport master (
        output ce,
        output data_in,
        input  data_out,
        input  valid_op,
        input  end_op,
        input  pause_inputs
    );
endinterface

// File: rtl/unpooler_line_buf.sv
// rtl/unpooler_line_buf.sv - one pooled row of samples, kept for the replay pass
//
// clk            : write clock
// we/waddr/wdata : synchronous write port
// raddr/rdata    : combinational read port
module unpooler_line_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 6,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    // Contents are deliberately not reset; every entry is rewritten before it is replayed.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/unpooler.sv
// rtl/unpooler.sv - nearest-neighbour 2x2 upsampler (inverse of the 2x2 pooler)
//
// clk          : system clock, rising edge
// master_rst_n : synchronous active-low reset, overrides ce
// bus          : slave side of unpooler_if (ce, data_in in; data_out, valid_op,
//                end_op, pause_inputs out)
module unpooler
    import unpooler_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IN_W   = 6,
    parameter int IN_H   = 6
) (
    input  logic       clk,
    input  logic       master_rst_n,
    unpooler_if.slave  bus
);
    localparam int CW = cnt_w(IN_W);
    // rcnt walks 0..2*IN_W-1; one bit more than col is always enough.
    localparam int RW = CW + 1;
    localparam int HW = cnt_w(IN_H);

    localparam logic [CW-1:0] COL_LAST  = CW'(IN_W - 1);
    localparam logic [RW-1:0] RCNT_LAST = RW'(2 * IN_W - 1);
    localparam logic [HW-1:0] ROW_LAST  = HW'(IN_H - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic [HW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              end_q, end_d;

    logic              buf_we;
    logic [DATA_W-1:0] buf_rdata;

    unpooler_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IN_W),
        .AW     (CW)
    ) u_line_buf (
        .clk    (clk),
        .we     (buf_we),
        .waddr  (col_q),
        .wdata  (bus.data_in),
        .raddr  (rcnt_q[CW:1]),
        .rdata  (buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (!master_rst_n) begin
            state_q    <= FILL_A;
            col_q      <= '0;
            rcnt_q     <= '0;
            row_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            rcnt_q     <= rcnt_d;
            row_q      <= row_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            end_q      <= end_d;
        end
    end

    // Defaults hold everything and drop the pulses, which is exactly the ce=0 behaviour.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        rcnt_d     = rcnt_q;
        row_d      = row_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        end_d      = 1'b0;
        buf_we     = 1'b0;

        if (bus.ce) begin
            unique case (state_q)
                FILL_A: begin
                    data_out_d = bus.data_in;
                    buf_we     = master_rst_n;
                    valid_d    = 1'b1;
                    state_d    = FILL_B;
                end
                FILL_B: begin
                    // data_out holds: this cycle emits the horizontal duplicate.
                    valid_d = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        rcnt_d  = '0;
                        state_d = REPLAY;
                    end else begin
                        col_d   = col_q + CW'(1);
                        state_d = FILL_A;
                    end
                end
                REPLAY: begin
                    data_out_d = buf_rdata;
                    valid_d    = 1'b1;
                    rcnt_d     = rcnt_q + RW'(1);
                    if (rcnt_q == RCNT_LAST) begin
                        // Leave with rcnt at 0 so FILL_A always starts from a clean count.
                        rcnt_d  = '0;
                        state_d = FILL_A;
                        if (row_q == ROW_LAST) begin
                            end_d = 1'b1;
                            row_d = '0;
                        end else begin
                            row_d = row_q + HW'(1);
                        end
                    end
                end
                default: begin
                    state_d = FILL_A;
                end
            endcase
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.valid_op     = valid_q;
    assign bus.end_op       = end_q;
    assign bus.pause_inputs = (state_q != FILL_A);

endmodule
